// File: rtl/spi_seq_pkg.sv
// Shared types and widths for the SPI transfer sequencer.
package spi_seq_pkg;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    GAP,
    END
  } state_t;
endpackage

// File: rtl/spi_xfer_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Storage is not reset, so the head is forced to zero while empty.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for an SPI master: TX/RX FIFOs plus a burst FSM that holds slave-select low.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYC    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              go,
  input  logic [LEN_W-1:0]  go_len,
  output logic              busy,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_ready,
  output logic              rx_ovf,
  output logic              spi_start,
  output logic [BYTE_W-1:0] spi_tx_data,
  output logic              spi_cpol,
  output logic              spi_cpha,
  input  logic              spi_ready,
  input  logic              spi_done,
  input  logic [BYTE_W-1:0] spi_rx_data,
  output logic              ss_n
);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic [BYTE_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic              rx_push;
  logic              rx_pop;
  logic              start_go;

  assign start_go = (state == IDLE) && go && (go_len != '0);
  assign tx_pop   = (state == SETUP) && !tx_empty && spi_ready && !rx_full;
  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign tx_ready = !tx_full || tx_pop;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_push  = (state == XFER) && spi_done;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign busy     = (state == SETUP) || (state == XFER) || (state == GAP);
  assign ss_n     = !busy;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_byte),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_rx_data),
    .pop       (rx_pop),
    .head      (rx_byte),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_go) state_nxt = SETUP;
      SETUP: if (tx_pop) state_nxt = XFER;
      XFER: begin
        if (spi_done) begin
          if (remaining == LEN_W'(1))  state_nxt = END;
          else if (GAP_CYC == 0)       state_nxt = SETUP;
          else                         state_nxt = GAP;
        end
      end
      GAP:   if (gap_cnt == GAP_LAST) state_nxt = SETUP;
      END:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      remaining   <= '0;
      gap_cnt     <= '0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      spi_cpol    <= 1'b0;
      spi_cpha    <= 1'b0;
      rx_ovf      <= 1'b0;
    end else begin
      state     <= state_nxt;
      spi_start <= tx_pop;
      if (tx_pop) spi_tx_data <= tx_head;
      if (start_go) begin
        remaining <= go_len;
        spi_cpol  <= cfg_cpol;
        spi_cpha  <= cfg_cpha;
        rx_ovf    <= 1'b0;
      end
      if (rx_push && (remaining != '0)) remaining <= remaining - 1'b1;
      // Unreachable while SETUP guards on RX space; kept as a loss indicator.
      if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end
endmodule
